// File: rtl/rst_seq_pkg.sv
// Shared types for the board-level reset sequencer: FSM states and reset-cause encoding.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK    = 2'd0,
    WAIT_RELEASE = 2'd1,
    HOLD         = 2'd2,
    RUN          = 2'd3
  } rst_state_e;

  typedef enum logic [1:0] {
    RstPor      = 2'd0,
    RstLockLoss = 2'd1,
    RstButton   = 2'd2,
    RstNdm      = 2'd3
  } rst_cause_e;

  // Idle level of the active-low board button
  localparam logic BtnReleased = 1'b1;

endpackage

// File: rtl/rst_debounce.sv
// Board button synchroniser and debouncer: btn_db_o follows the button only after
// it has differed from the accepted level for DebounceCycles consecutive cycles.
module rst_debounce
  import rst_seq_pkg::*;
#(
  parameter int unsigned DebounceCycles = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_rst_ni,
  output logic btn_db_o
);

  localparam int unsigned DbW = $clog2(DebounceCycles + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DebounceCycles - 1);

  logic [1:0]     r_btn_sync;
  logic [DbW-1:0] r_db_cnt;
  logic           r_btn_db;
  logic           w_btn_s;
  logic [DbW-1:0] w_db_cnt_d;
  logic           w_btn_db_d;

  assign w_btn_s  = r_btn_sync[1];
  assign btn_db_o = r_btn_db;

  // Debounce counter: restart whenever the synchronised button agrees with the accepted level
  always_comb begin
    w_db_cnt_d = r_db_cnt;
    w_btn_db_d = r_btn_db;
    if (w_btn_s == r_btn_db) begin
      w_db_cnt_d = {DbW{1'b0}};
    end else if (r_db_cnt == DbLast) begin
      w_btn_db_d = w_btn_s;
      w_db_cnt_d = {DbW{1'b0}};
    end else begin
      w_db_cnt_d = r_db_cnt + DbW'(1);
    end
  end

  // Synchroniser, debounce counter and accepted button level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_btn_sync <= {BtnReleased, BtnReleased};
      r_db_cnt   <= {DbW{1'b0}};
      r_btn_db   <= BtnReleased;
    end else begin
      r_btn_sync <= {r_btn_sync[0], btn_rst_ni};
      r_db_cnt   <= w_db_cnt_d;
      r_btn_db   <= w_btn_db_d;
    end
  end

endmodule

// File: rtl/rst_sys_seq.sv
// System reset sequencer: merges PLL lock, debounced button and debug NDM request into
// one registered, glitch-free active-low reset, and records cause and count of resets.
module rst_sys_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned HoldCycles     = 16,
  parameter int unsigned DebounceCycles = 8,
  parameter int unsigned CntW           = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pll_locked_i,
  input  logic            btn_rst_ni,
  input  logic            ndmreset_req_i,
  output logic            rst_sys_no,
  output logic [1:0]      rst_cause_o,
  output logic [CntW-1:0] rst_count_o
);

  localparam int unsigned HoldW = $clog2(HoldCycles + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

  logic [1:0]       r_lock_sync;
  logic             r_ndm_q;
  rst_state_e       r_state;
  logic [HoldW-1:0] r_hold_cnt;
  rst_cause_e       r_cause;
  logic [CntW-1:0]  r_count;
  logic             r_rst_sys;

  logic             w_lock_s;
  logic             w_btn_db;
  logic             w_ndm_req;
  rst_state_e       w_state_d;
  logic [HoldW-1:0] w_hold_cnt_d;
  rst_cause_e       w_cause_d;
  logic             w_leave_run;
  logic [CntW-1:0]  w_count_d;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    if (v == {CntW{1'b1}}) begin
      return v;
    end else begin
      return v + CntW'(1);
    end
  endfunction

  rst_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_debounce (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .btn_rst_ni(btn_rst_ni),
    .btn_db_o  (w_btn_db)
  );

  assign w_lock_s    = r_lock_sync[1];
  assign w_ndm_req   = ndmreset_req_i & ~r_ndm_q;
  assign rst_sys_no  = r_rst_sys;
  assign rst_cause_o = r_cause;
  assign rst_count_o = r_count;

  // Next-state logic; cause and count only move on the edge that leaves RUN
  always_comb begin
    w_state_d    = r_state;
    w_hold_cnt_d = r_hold_cnt;
    w_cause_d    = r_cause;
    w_leave_run  = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s && w_btn_db) begin
          w_state_d    = HOLD;
          w_hold_cnt_d = {HoldW{1'b0}};
        end else if (w_lock_s) begin
          w_state_d = WAIT_RELEASE;
        end else begin
          w_state_d = WAIT_LOCK;
        end
      end
      WAIT_RELEASE: begin
        if (!w_lock_s) begin
          w_state_d = WAIT_LOCK;
        end else if (w_btn_db) begin
          w_state_d    = HOLD;
          w_hold_cnt_d = {HoldW{1'b0}};
        end else begin
          w_state_d = WAIT_RELEASE;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_state_d = WAIT_LOCK;
        end else if (!w_btn_db) begin
          w_state_d = WAIT_RELEASE;
        end else if (r_hold_cnt == HoldLast) begin
          w_state_d = RUN;
        end else begin
          w_hold_cnt_d = r_hold_cnt + HoldW'(1);
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_d   = WAIT_LOCK;
          w_cause_d   = RstLockLoss;
          w_leave_run = 1'b1;
        end else if (!w_btn_db) begin
          w_state_d   = WAIT_RELEASE;
          w_cause_d   = RstButton;
          w_leave_run = 1'b1;
        end else if (w_ndm_req) begin
          w_state_d    = HOLD;
          w_hold_cnt_d = {HoldW{1'b0}};
          w_cause_d    = RstNdm;
          w_leave_run  = 1'b1;
        end else begin
          w_state_d = RUN;
        end
      end
      default: begin
        w_state_d = WAIT_LOCK;
      end
    endcase
  end

  // Saturating reset counter
  always_comb begin
    w_count_d = r_count;
    if (w_leave_run) begin
      w_count_d = sat_inc(r_count);
    end else begin
      w_count_d = r_count;
    end
  end

  // Lock synchroniser, NDM edge register, FSM state and registered reset output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_sync <= 2'b00;
      r_ndm_q     <= 1'b0;
      r_state     <= WAIT_LOCK;
      r_hold_cnt  <= {HoldW{1'b0}};
      r_cause     <= RstPor;
      r_count     <= {CntW{1'b0}};
      r_rst_sys   <= 1'b0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_locked_i};
      r_ndm_q     <= ndmreset_req_i;
      r_state     <= w_state_d;
      r_hold_cnt  <= w_hold_cnt_d;
      r_cause     <= w_cause_d;
      r_count     <= w_count_d;
      r_rst_sys   <= (w_state_d == RUN);
    end
  end

endmodule
